pipeline_skid_register: RTL and testbench

Two-entry valid/ready pipeline register for inter-stage transfers in the processor datapath. It is the consumer-facing counterpart of the free-running capture flops: the downstream stage throttles it through OutReady. It still sustains one transfer per cycle with registered InReady, so no combinational ready path crosses stages. A synchronous Flush discards in-flight data on branch/exception redirect.

---
 rtl/pipeline_skid_register_pkg.sv | 13 +
 rtl/pipeline_data_register.sv | 33 +++
 rtl/pipeline_skid_register.sv | 126 ++++++++++++
 tb/tb_pipeline_skid_register.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pipeline_skid_register_pkg.sv
// Shared definitions for the pipeline register stages: state encoding and
// the default datapath width.
package pipeline_skid_register_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BUSY  = 2'b01,
        ST_FULL  = 2'b10
    } pipe_state_e;

    localparam int DATA_WIDTH_DEFAULT = 32;

endpackage

// File: rtl/pipeline_data_register.sv
// WIDTH-bit data register with load enable and asynchronous active-high
// clear; used for both the main and skid entries of the pipeline register.
module pipeline_data_register #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (load_en) begin
            data_d = data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_out = data_q;

endmodule

// File: rtl/pipeline_skid_register.sv
// Two-entry valid/ready pipeline register with registered InReady/OutValid
// and a synchronous flush for redirects.
//
//   state | meaning
//   EMPTY | nothing held; OutValid=0, InReady=1
//   BUSY  | main entry holds one word; OutValid=1, InReady=1
//   FULL  | main and skid entries hold words; OutValid=1, InReady=0
module pipeline_skid_register
    import pipeline_skid_register_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Flush,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] InData,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] OutData
);

    pipe_state_e      state_q;
    pipe_state_e      state_d;
    logic             out_valid_q;
    logic             out_valid_d;
    logic             in_ready_q;
    logic             in_ready_d;

    logic             in_xfer;
    logic             out_xfer;
    logic             main_load;
    logic             skid_load;
    logic             main_from_skid;
    logic [WIDTH-1:0] main_in;
    logic [WIDTH-1:0] skid_data;

    assign in_xfer  = InValid && in_ready_q;
    assign out_xfer = out_valid_q && OutReady;

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;

        case (state_q)
            ST_EMPTY: begin
                if (in_xfer) begin
                    state_d   = ST_BUSY;
                    main_load = 1'b1;
                end
            end
            ST_BUSY: begin
                if (in_xfer && out_xfer) begin
                    main_load = 1'b1;
                end else if (in_xfer) begin
                    state_d   = ST_FULL;
                    skid_load = 1'b1;
                end else if (out_xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_xfer) begin
                    state_d        = ST_BUSY;
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        // Flush drops every transfer of this cycle; data contents become don't-care.
        if (Flush) begin
            state_d        = ST_EMPTY;
            main_load      = 1'b0;
            skid_load      = 1'b0;
            main_from_skid = 1'b0;
        end

        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_FULL);
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign main_in = main_from_skid ? skid_data : InData;

    pipeline_data_register #(
        .WIDTH (WIDTH)
    ) u_main_entry (
        .clk      (CLK),
        .rst      (Reset),
        .load_en  (main_load),
        .data_in  (main_in),
        .data_out (OutData)
    );

    pipeline_data_register #(
        .WIDTH (WIDTH)
    ) u_skid_entry (
        .clk      (CLK),
        .rst      (Reset),
        .load_en  (skid_load),
        .data_in  (InData),
        .data_out (skid_data)
    );

    assign OutValid = out_valid_q;
    assign InReady  = in_ready_q;

endmodule

// File: tb/tb_pipeline_skid_register.sv
// Directed and randomised checks of pipeline_skid_register: reset, streaming,
// backpressure, flush, simultaneous transfers and FIFO ordering.
module tb_pipeline_skid_register;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        Flush;
    logic        InValid;
    logic        InReady;
    logic [31:0] InData;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] OutData;

    int n_cmp = 0;
    int n_err = 0;

    pipeline_skid_register #(.WIDTH(32)) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .Flush    (Flush),
        .InValid  (InValid),
        .InReady  (InReady),
        .InData   (InData),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .OutData  (OutData)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ov, input logic ir, input logic [31:0] od);
        chk({tag, "_ov"}, {31'd0, OutValid}, {31'd0, ov});
        chk({tag, "_ir"}, {31'd0, InReady}, {31'd0, ir});
        if (ov) chk({tag, "_od"}, OutData, od);
    endtask

    logic [31:0] q[$];
    logic        iv;
    logic        ordy;
    logic        exp_ov;
    logic        exp_ir;

    initial begin
        Reset    = 1'b1;
        Flush    = 1'b0;
        InValid  = 1'b0;
        InData   = 32'h0;
        OutReady = 1'b0;
        #2;
        chk("rst_ov", {31'd0, OutValid}, 32'd0);
        chk("rst_ir", {31'd0, InReady}, 32'd1);
        chk("rst_od", OutData, 32'd0);
        tick();
        tick();
        Reset = 1'b0;
        tick();

        // Streaming 0x11..0x15 with OutReady high
        OutReady = 1'b1;
        InValid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            InData = 32'h11 + i;
            tick();
            chk_out("stream", 1'b1, 1'b1, 32'h11 + i);
        end
        InValid = 1'b0;
        InData  = 32'hx;
        tick();
        chk_out("stream_drain", 1'b0, 1'b1, 32'h0);

        // Backpressure
        OutReady = 1'b0;
        InValid  = 1'b1;
        InData   = 32'hA1;
        tick();
        chk_out("bp_a1", 1'b1, 1'b1, 32'hA1);
        InData = 32'hA2;
        tick();
        chk_out("bp_full", 1'b1, 1'b0, 32'hA1);
        InData = 32'hA3;
        tick();
        chk_out("bp_hold", 1'b1, 1'b0, 32'hA1);
        tick();
        chk_out("bp_hold2", 1'b1, 1'b0, 32'hA1);
        OutReady = 1'b1;
        tick();
        chk_out("bp_a2", 1'b1, 1'b1, 32'hA2);
        tick();
        chk_out("bp_a3", 1'b1, 1'b1, 32'hA3);
        InValid = 1'b0;
        tick();
        chk_out("bp_empty", 1'b0, 1'b1, 32'h0);

        // Asynchronous reset while FULL
        OutReady = 1'b0;
        InValid  = 1'b1;
        InData   = 32'hB1;
        tick();
        InData = 32'hB2;
        tick();
        chk_out("prerst_full", 1'b1, 1'b0, 32'hB1);
        InValid = 1'b0;
        #2;
        Reset = 1'b1;
        #1;
        chk("arst_ov", {31'd0, OutValid}, 32'd0);
        chk("arst_ir", {31'd0, InReady}, 32'd1);
        chk("arst_od", OutData, 32'd0);
        #1;
        Reset = 1'b0;
        tick();
        chk_out("postrst", 1'b0, 1'b1, 32'h0);

        // Flush while FULL with both handshakes offered
        InValid = 1'b1;
        InData  = 32'hC1;
        tick();
        InData = 32'hC2;
        tick();
        chk_out("prefl_full", 1'b1, 1'b0, 32'hC1);
        Flush    = 1'b1;
        OutReady = 1'b1;
        InData   = 32'hC3;
        tick();
        chk_out("flush", 1'b0, 1'b1, 32'h0);
        Flush   = 1'b0;
        InValid = 1'b0;
        tick();
        chk_out("flush_idle", 1'b0, 1'b1, 32'h0);
        InValid = 1'b1;
        InData  = 32'hD1;
        tick();
        chk_out("postfl_d1", 1'b1, 1'b1, 32'hD1);
        InValid = 1'b0;
        tick();
        chk_out("postfl_empty", 1'b0, 1'b1, 32'h0);

        // Simultaneous transfers in BUSY
        OutReady = 1'b0;
        InValid  = 1'b1;
        InData   = 32'h55;
        tick();
        chk_out("sim_55", 1'b1, 1'b1, 32'h55);
        OutReady = 1'b1;
        InData   = 32'h66;
        tick();
        chk_out("sim_66", 1'b1, 1'b1, 32'h66);
        InValid = 1'b0;
        tick();
        chk_out("sim_empty", 1'b0, 1'b1, 32'h0);

        // Randomised traffic against a FIFO model
        q.delete();
        for (int c = 0; c < 1000; c++) begin
            exp_ov = (q.size() > 0);
            exp_ir = (q.size() < 2);
            chk("rnd_ov", {31'd0, OutValid}, {31'd0, exp_ov});
            chk("rnd_ir", {31'd0, InReady}, {31'd0, exp_ir});
            if (exp_ov) chk("rnd_od", OutData, q[0]);
            iv       = ($urandom_range(0, 3) != 0);
            ordy     = ($urandom_range(0, 2) != 0);
            InValid  = iv;
            OutReady = ordy;
            InData   = iv ? $urandom() : 32'hx;
            if (exp_ov && ordy) void'(q.pop_front());
            if (iv && exp_ir) q.push_back(InData);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
